uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Serial receive front-end that sits directly upstream of the computer core's UART register.
- Samples the asynchronous `uart_rx` pin and deframes 8N1 characters (LSB first).
- Buffers received bytes in a small first-word-fall-through (FWFT) FIFO and presents them to the core through a pop handshake.
- Raises a level interrupt request while data is waiting. The output feeds the core's `intr` line via the top-level interrupt OR.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit. 16 gives 160 ns bits at the 10 ns system clock. Minimum 4; must be even.
- DEPTH, 4: FIFO entries. Power of two, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  asynchronous serial input, idle high.
- rd_en  in  1  pop request from core. Ignored when `rx_valid` = 0.
- err_clr  in  1  single-cycle clear of the sticky error flags.
- rx_data  out  8  FIFO head byte. Valid while `rx_valid` = 1.
- rx_valid  out  1  FIFO not empty.
- rx_irq  out  1  interrupt request, equal to `rx_valid`.
- fifo_full  out  1  FIFO holds DEPTH entries.
- frame_err  out  1  sticky: stop bit sampled low.
- overrun  out  1  sticky: byte dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, `reset_n` = 0):
  - All outputs 0: `rx_data` = 8'h00, `rx_valid`, `rx_irq`, `fifo_full`, `frame_err` and `overrun` all low.
  - FSM returns to IDLE; FIFO pointers and count cleared.
  - Synchronizer flops reset to 1 (line idle).
  - A character in flight when reset asserts is discarded.
- Input sync: 2-flop synchronizer on `uart_rx`. The FSM uses only the synchronized value `rxs`.
- Bit counter: 4 bits; sample counter sized for CLKS_PER_BIT.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when `rxs` = 0, go to START and clear the sample counter.
  - START: after CLKS_PER_BIT/2 cycles, sample `rxs`.
    - If 1 (glitch), return to IDLE with no error.
    - If 0, go to DATA with the bit index at 0.
  - DATA: every CLKS_PER_BIT cycles, sample `rxs` into shift register bit[index], LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rxs`.
    - If 1, push the byte.
    - If 0, set `frame_err` and discard the byte.
    - Either way, go to IDLE in the same cycle. This permits a back-to-back start bit with no idle time.
- Sample timing: the stop sample occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the cycle in which IDLE first sees `rxs` = 0.
- FIFO write: a push writes the byte into the FIFO on the stop-sample edge. `rx_valid` rises on the following cycle.
- FIFO read, FWFT:
  - `rx_data` always reflects the head entry.
  - `rd_en` with `rx_valid` = 1 pops on the clock edge; the next entry, or empty, is visible the following cycle.
- Push while full:
  - With `rd_en` = 0 in the same cycle: the byte is dropped, `overrun` is set, and FIFO contents are unchanged.
  - With `rd_en` = 1 in the same cycle: pop and push both succeed, and the count stays at DEPTH.
- Push and pop on a non-empty, non-full FIFO in the same cycle: both succeed; the count is unchanged.
- Pop on empty: no effect; pointers unchanged.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty is derived from a separate count register (0..DEPTH).
- Error flags:
  - `frame_err` and `overrun` clear only on `err_clr` or reset.
  - If `err_clr` and a new error event occur in the same cycle, the set wins.
- Break condition (`rxs` held low): each 10-bit period produces one framing error.
  - After STOP returns to IDLE, the still-low line starts a new character.
  - No bytes are pushed during a break.
- `rx_irq` is a registered copy of the `rx_valid` state, with no extra latency relative to `rx_valid`.

Test Plan (CLKS_PER_BIT = 16, 10 ns clk, 160 ns bits):
1. Reset release, line idle high for 1 µs -> `rx_valid` = 0, `rx_data` = 8'h00, all flags 0, FSM in IDLE.
2. Send 8'h55 framed 0,1,0,1,0,1,0,1,0,1 -> `rx_valid` and `rx_irq` rise one cycle after the stop sample. `rx_data` = 8'h55. One `rd_en` pulse -> `rx_valid` = 0 on the next cycle.
3. Low pulse of 60 ns on an idle line -> START mid-sample reads 1; no push, `frame_err` = 0, FSM back in IDLE.
4. Send 8'hA3 with the stop bit driven low -> `frame_err` = 1, `rx_valid` stays 0. `err_clr` pulse -> `frame_err` = 0.
5. Send 5 back-to-back bytes 8'h01..8'h05 with no pops -> `fifo_full` = 1 after the 4th, `overrun` = 1 after the 5th. Pops return 01, 02, 03, 04, then `rx_valid` = 0.
6. With the FIFO full, assert `rd_en` in the exact stop-sample cycle of 8'h06 -> no overrun, count stays 4. Draining returns 02, 03, 04, 06. Then assert `reset_n` = 0 mid-character -> all outputs 0 immediately; that character is never delivered.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Serial receive front-end for the core's UART register. The asynchronous
// uart_rx pin is brought into the clock domain by a 2-flop synchronizer.
// 8N1 characters (LSB first) are deframed from the synchronized line, and
// good bytes are buffered in a small first-word-fall-through FIFO. The core
// pops bytes with rd_en. rx_irq requests service while data is waiting.
//
// Handshake (pop side): rx_valid high means rx_data holds the FIFO head.
// The core asserts rd_en for one cycle to consume it. A pop happens on the
// rising edge where rd_en = 1 and rx_valid = 1. The next entry, or empty,
// is visible the following cycle. rd_en while rx_valid = 0 is ignored.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   uart_rx    in   asynchronous serial input, idle high
//   rd_en      in   pop request from the core
//   err_clr    in   single-cycle clear of frame_err / overrun
//   rx_data    out  FIFO head byte (8'h00 while empty)
//   rx_valid   out  FIFO not empty
//   rx_irq     out  interrupt request, same timing as rx_valid
//   fifo_full  out  FIFO holds DEPTH entries
//   frame_err  out  sticky: a stop bit was sampled low
//   overrun    out  sticky: a byte was dropped because the FIFO was full
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (even, >= 4)
//   DEPTH         FIFO entries (power of two, >= 2)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DEPTH        = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       uart_rx,
   input  logic       rd_en,
   input  logic       err_clr,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_irq,
   output logic       fifo_full,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = $clog2(DEPTH + 1);

   localparam logic [CW-1:0]   HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]   FULL_M1   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronizer. Resets to 1 so a reset never looks like a
   // start bit.
   // ------------------------------------------------------------------
   logic rx_meta;
   logic rxs;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rxs     <= rx_meta;
      end
   end

   // ------------------------------------------------------------------
   // Deframing FSM
   // ------------------------------------------------------------------
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    idx_q, idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          push_req;
   logic          stop_bad;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      push_req = 1'b0;
      stop_bad = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rxs) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            // Re-check the line at the middle of the start bit. A high
            // level here was a glitch and is discarded silently.
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               if (rxs) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  idx_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            // Sampling is anchored to mid-start, so every full bit
            // period lands in the middle of the next data bit.
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               shreg_d[idx_q[2:0]] = rxs;
               if (idx_q == 4'd7) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            // Return to IDLE on the sample edge itself so a start bit
            // that follows the stop bit directly is not missed. A line
            // held low (break) therefore restarts a character at once.
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rxs) begin
                  push_req = 1'b1;
               end else begin
                  stop_bad = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FWFT FIFO. Full/empty come from the count register; pointers only
   // address storage and wrap naturally at DEPTH.
   // ------------------------------------------------------------------
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CNTW-1:0] count_q, count_d;
   logic            valid_q, irq_q, full_q;
   logic            is_empty, is_full;
   logic            do_pop, do_push, drop;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == DEPTH_CNT);
   assign do_pop   = rd_en && !is_empty;
   // A pop in the same cycle frees the slot the push needs.
   assign do_push  = push_req && (!is_full || do_pop);
   assign drop     = push_req && is_full && !do_pop;

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q] <= shreg_d;
      end
   end

   // valid/irq/full are registered from the next count so they change
   // on the same edge as the count itself, without an extra cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
         irq_q    <= 1'b0;
         full_q   <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
         valid_q <= (count_d != '0);
         irq_q   <= (count_d != '0);
         full_q  <= (count_d == DEPTH_CNT);
      end
   end

   // ------------------------------------------------------------------
   // Sticky error flags. A new event beats a simultaneous clear.
   // ------------------------------------------------------------------
   logic frame_err_q, overrun_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (stop_bad) begin
            frame_err_q <= 1'b1;
         end else if (err_clr) begin
            frame_err_q <= 1'b0;
         end
         if (drop) begin
            overrun_q <= 1'b1;
         end else if (err_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   // Head byte is forced to zero while empty so stale storage never
   // shows up on the bus (and reset reads as 8'h00).
   assign rx_data   = valid_q ? mem[rd_ptr_q] : 8'h00;
   assign rx_valid  = valid_q;
   assign rx_irq    = irq_q;
   assign fifo_full = full_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed bench for uart_rx_fifo with CLKS_PER_BIT = 16 and DEPTH = 4.
// Serial frames are driven bit by bit on the falling clock edge; outputs
// are sampled on the falling edge. Frame timing: with the start bit driven
// just before rising edge 1, the stop sample is rising edge 155, so
// rx_valid is still low when sampled before edge 155 and high before 156.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       reset_n;
   logic       uart_rx;
   logic       rd_en;
   logic       err_clr;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_irq;
   logic       fifo_full;
   logic       frame_err;
   logic       overrun;

   always #5 clk = ~clk;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .uart_rx   (uart_rx),
      .rd_en     (rd_en),
      .err_clr   (err_clr),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_irq    (rx_irq),
      .fifo_full (fifo_full),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   localparam logic [31:0] ST_IDLE  = 32'd0;
   localparam logic [31:0] ST_START = 32'd1;

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   logic v_pre, v_post, irq_post;

   // Drives ncyc cycles of a frame. pop_at / clr_at pulse rd_en / err_clr
   // in the cycle ending at that rising edge (0 = never).
   task automatic drive_frame(input logic [7:0] d, input logic stop,
                              input int pop_at, input int clr_at, input int ncyc);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      for (int p = 1; p <= ncyc; p++) begin
         @(negedge clk);
         if (((p - 1) % CPB) == 0) uart_rx = bits[(p - 1) / CPB];
         rd_en   = (p == pop_at);
         err_clr = (p == clr_at);
         if (p == 155) v_pre = rx_valid;
         if (p == 156) begin
            v_post   = rx_valid;
            irq_post = rx_irq;
         end
      end
      rd_en   = 1'b0;
      err_clr = 1'b0;
   endtask

   task automatic pop_check(input string name);
      logic [7:0] exp;
      exp = exp_q.pop_front();
      @(negedge clk);
      chk({name, "_valid"}, rx_valid, 1);
      chk({name, "_data"}, rx_data, exp);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         clr_at;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{data: 8'h55, stop: 1'b1, clr_at: 0,   exp_valid: 1'b1, exp_data: 8'h55, exp_ferr: 1'b0};
      vecs[1] = '{data: 8'hA3, stop: 1'b0, clr_at: 0,   exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};
      vecs[2] = '{data: 8'h3C, stop: 1'b0, clr_at: 155, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};
      vecs[3] = '{data: 8'h00, stop: 1'b1, clr_at: 0,   exp_valid: 1'b1, exp_data: 8'h00, exp_ferr: 1'b0};
      vecs[4] = '{data: 8'hFF, stop: 1'b1, clr_at: 0,   exp_valid: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};
      vecs[5] = '{data: 8'h80, stop: 1'b1, clr_at: 0,   exp_valid: 1'b1, exp_data: 8'h80, exp_ferr: 1'b0};
      vecs[6] = '{data: 8'hC5, stop: 1'b1, clr_at: 0,   exp_valid: 1'b1, exp_data: 8'hC5, exp_ferr: 1'b0};

      // ---- reset and idle line ----
      reset_n = 1'b0;
      uart_rx = 1'b1;
      rd_en   = 1'b0;
      err_clr = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("rst_valid", rx_valid, 0);
      chk("rst_irq", rx_irq, 0);
      chk("rst_data", rx_data, 8'h00);
      chk("rst_full", fifo_full, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_state", 32'(dut.state_q), ST_IDLE);

      // ---- table: single frames ----
      for (int i = 0; i < 7; i++) begin
         drive_frame(vecs[i].data, vecs[i].stop, 0, vecs[i].clr_at, 160);
         uart_rx = 1'b1;
         chk("tbl_valid_pre", v_pre, 0);
         chk("tbl_valid_post", v_post, vecs[i].exp_valid);
         chk("tbl_irq_post", irq_post, vecs[i].exp_valid);
         repeat (20) @(negedge clk);
         chk("tbl_valid", rx_valid, vecs[i].exp_valid);
         chk("tbl_irq", rx_irq, vecs[i].exp_valid);
         chk("tbl_data", rx_data, vecs[i].exp_data);
         chk("tbl_ferr", frame_err, vecs[i].exp_ferr);
         chk("tbl_ovr", overrun, 0);
         chk("tbl_state", 32'(dut.state_q), ST_IDLE);
         if (vecs[i].exp_valid) begin
            @(negedge clk);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            chk("tbl_pop_valid", rx_valid, 0);
            chk("tbl_pop_irq", rx_irq, 0);
         end
         if (vecs[i].exp_ferr) begin
            pulse_clr();
            chk("tbl_ferr_clr", frame_err, 0);
         end
      end

      // ---- 60 ns glitch on idle line ----
      for (int p = 1; p <= 60; p++) begin
         @(negedge clk);
         uart_rx = (p <= 6) ? 1'b0 : 1'b1;
         if (p == 6) chk("glitch_in_start", 32'(dut.state_q), ST_START);
      end
      chk("glitch_state", 32'(dut.state_q), ST_IDLE);
      chk("glitch_ferr", frame_err, 0);
      chk("glitch_valid", rx_valid, 0);

      // ---- break: one framing error per 10-bit period ----
      for (int p = 1; p <= 420; p++) begin
         @(negedge clk);
         uart_rx = (p < 310) ? 1'b0 : 1'b1;
         err_clr = (p == 200);
         if (p == 150) chk("brk_ferr_early", frame_err, 0);
         if (p == 160) chk("brk_ferr_1", frame_err, 1);
         if (p == 202) chk("brk_ferr_cleared", frame_err, 0);
         if (p == 309) chk("brk_ferr_2", frame_err, 1);
      end
      err_clr = 1'b0;
      chk("brk_valid", rx_valid, 0);
      chk("brk_state", 32'(dut.state_q), ST_IDLE);
      pulse_clr();
      chk("brk_clr", frame_err, 0);

      // ---- five back-to-back bytes, no pops ----
      for (int i = 1; i <= 5; i++) begin
         drive_frame(8'(i), 1'b1, 0, 0, 160);
         if (i <= DEPTH) exp_q.push_back(8'(i));
         if (i == 3) chk("b2b_full_3", fifo_full, 0);
         if (i == 4) begin
            chk("b2b_full_4", fifo_full, 1);
            chk("b2b_ovr_4", overrun, 0);
         end
         if (i == 5) begin
            chk("b2b_full_5", fifo_full, 1);
            chk("b2b_ovr_5", overrun, 1);
         end
      end
      repeat (5) @(negedge clk);
      while (exp_q.size() > 0) pop_check("b2b_pop");
      @(negedge clk);
      chk("b2b_empty", rx_valid, 0);
      // Pop on empty must leave pointers alone.
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      chk("empty_pop_valid", rx_valid, 0);
      pulse_clr();
      chk("ovr_clr", overrun, 0);

      // ---- refill, then pop in the exact stop-sample cycle ----
      for (int i = 1; i <= 4; i++) drive_frame(8'(i), 1'b1, 0, 0, 160);
      chk("refill_full", fifo_full, 1);
      drive_frame(8'h06, 1'b1, 155, 0, 160);
      repeat (5) @(negedge clk);
      chk("pp_ovr", overrun, 0);
      chk("pp_full", fifo_full, 1);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h04);
      exp_q.push_back(8'h06);
      while (exp_q.size() > 0) pop_check("pp_pop");
      @(negedge clk);
      chk("pp_empty", rx_valid, 0);

      // ---- reset mid-character ----
      drive_frame(8'hA3, 1'b0, 0, 0, 160);
      uart_rx = 1'b1;
      repeat (20) @(negedge clk);
      drive_frame(8'h77, 1'b1, 0, 0, 160);
      chk("pre_rst_valid", rx_valid, 1);
      chk("pre_rst_ferr", frame_err, 1);
      drive_frame(8'h99, 1'b1, 0, 0, 60);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", rx_valid, 0);
      chk("mid_rst_irq", rx_irq, 0);
      chk("mid_rst_data", rx_data, 8'h00);
      chk("mid_rst_ferr", frame_err, 0);
      chk("mid_rst_state", 32'(dut.state_q), ST_IDLE);
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (250) @(negedge clk);
      chk("post_rst_valid", rx_valid, 0);
      chk("post_rst_ferr", frame_err, 0);
      chk("post_rst_state", 32'(dut.state_q), ST_IDLE);

      // ---- report ----
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
